ripple_cnt_reader: RTL
======================

// Module: ripple_cnt_reader
// PURPOSE
//  Clock-domain reader for the asynchronous T-FF ripple counter. Counter bits ripple with
//  per-stage clock-to-Q delay, so a raw sample can be mid-ripple and invalid. This block:
//   - synchronizes every bit into clk;
//   - on request, waits until the synchronized value holds for STABLE_CYCLES consecutive edges;
//   - returns the value and its modular delta from the previous good read.
// PARAMETERS
//  WIDTH          8  counter width in bits (>=2)
//  SYNC_STAGES    2  flops per bit in input synchronizer (>=2)
//  STABLE_CYCLES  3  consecutive equal samples required for a good read (>=1)
//  MAX_RETRY      4  mismatches tolerated before the read aborts with rd_err (>=1)
//  WRAP_W         8  wrap counter width (used only with RIPPLE_RD_WRAP_CNT_EN)
// PORTS
//  clk        in   1       reader clock
//  rstn       in   1       asynchronous, active-low reset
//  cnt_in     in   WIDTH   ripple counter Q bits, asynchronous to clk
//  rd_req     in   1       read request, sampled only in IDLE
//  busy       out  1       high while a read is in progress (WAIT)
//  rd_valid   out  1       one-cycle pulse: rd_value/rd_delta/rd_err valid
//  rd_value   out  WIDTH   captured count
//  rd_delta   out  WIDTH   rd_value - last good value, mod 2^WIDTH
//  rd_err     out  1       read aborted: input never settled
//  wrap_cnt   out  WRAP_W  wrap events (present only with RIPPLE_RD_WRAP_CNT_EN)
// BEHAVIOUR
//  Reset: all outputs, synchronizer flops, samp_prev, last_val, stable_cnt, retry_cnt = 0; state IDLE.
//  Synchronizer: cnt_sync = cnt_in through SYNC_STAGES flops per bit.
//   samp_prev <= cnt_sync on every edge, in all states.
//  FSM:
//   IDLE: rd_req=1 -> WAIT; clear stable_cnt and retry_cnt. rd_req=0 -> stay in IDLE.
//   WAIT (busy=1), evaluated each edge:
//    - cnt_sync==samp_prev: stable_cnt++.
//    - cnt_sync!=samp_prev: stable_cnt=0, retry_cnt++.
//    - Good read: on the edge where stable_cnt reaches STABLE_CYCLES:
//      rd_value=cnt_sync, rd_delta=cnt_sync-last_val, rd_err=0, last_val=cnt_sync,
//      rd_valid=1, -> IDLE.
//    - Abort: on the edge where retry_cnt reaches MAX_RETRY:
//      rd_value=cnt_sync, rd_delta=0, rd_err=1, last_val unchanged, rd_valid=1, -> IDLE.
//  Latency: with static input, rd_valid is high in the cycle after edge k+STABLE_CYCLES,
//   where edge k is the edge that sampled rd_req.
//  rd_valid: exactly one cycle. rd_value, rd_delta and rd_err hold until the next completion.
//  rd_req while busy, or on the completion edge: ignored, not queued.
//  Delta arithmetic: WIDTH-bit unsigned subtract, wraps naturally.
//   First read after reset: delta = value - 0.
//  Reset mid-WAIT: read abandoned, no rd_valid, last_val = 0.
// CONFIGURATION
//  RIPPLE_RD_WRAP_CNT_EN defined:
//   - wrap_cnt port exists.
//   - On each good read with cnt_sync < last_val: wrap_cnt++, saturating at 2^WRAP_W-1.
//   - Abort reads never count.
//   - wrap_cnt resets to 0.
//  Not defined: wrap_cnt port and its logic are absent. All other behaviour is identical.
// TESTING
//  Defaults used, except T4 (MAX_RETRY=4 explicitly).
//  T1: cnt_in static 0x5A, rd_req pulse -> rd_valid after 3 edges; value=0x5A, delta=0x5A, err=0.
//  T2: after T1, cnt_in=0x60, read -> value=0x60, delta=0x06.
//  T3 (macro on): last_val=0xF0, cnt_in=0x10, read -> delta=0x20, wrap_cnt=1.
//      Same stimulus with macro off: wrap_cnt port absent.
//  T4: cnt_in changes every clk, MAX_RETRY=4 -> rd_valid with rd_err=1, delta=0, last_val kept.
//  T5: rstn low 2 cycles into WAIT -> busy=0, no rd_valid, outputs=0.
//      Next read of 0x22 -> delta=0x22.
//  T6: rd_req held high through a read and the completion edge -> exactly one rd_valid pulse
//      per accepted request; busy drops for at least one cycle between reads.

Source files
------------

// File: rtl/ripple_cnt_reader.sv
// ripple_cnt_reader: clk-domain reader for an asynchronous T-FF ripple counter.
// Synchronizes the counter bits, waits for a stable value on request, and reports
// the value plus its modular delta from the previous good read.
// Optional feature: define RIPPLE_RD_WRAP_CNT_EN to add the saturating wrap_cnt output.
module ripple_cnt_reader #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 3,
    parameter int unsigned MAX_RETRY     = 4
`ifdef RIPPLE_RD_WRAP_CNT_EN
    ,
    parameter int unsigned WRAP_W        = 8
`endif
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             rd_req,
    output logic             busy,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_value,
    output logic [WIDTH-1:0] rd_delta,
    output logic             rd_err
`ifdef RIPPLE_RD_WRAP_CNT_EN
    ,
    output logic [WRAP_W-1:0] wrap_cnt
`endif
);

    localparam int unsigned SCW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned RCW = $clog2(MAX_RETRY + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] cnt_sync;
    logic [WIDTH-1:0] samp_prev;
    logic [WIDTH-1:0] last_val;
    logic [WIDTH-1:0] last_val_d;
    logic [SCW-1:0]   stable_cnt;
    logic [SCW-1:0]   stable_cnt_d;
    logic [RCW-1:0]   retry_cnt;
    logic [RCW-1:0]   retry_cnt_d;

    logic             busy_d;
    logic             rd_valid_d;
    logic [WIDTH-1:0] rd_value_d;
    logic [WIDTH-1:0] rd_delta_d;
    logic             rd_err_d;

    logic             samp_eq;
    logic             good_rd;
    logic             abort_rd;

    assign cnt_sync = sync_q[SYNC_STAGES-1];
    assign samp_eq  = (cnt_sync == samp_prev);
    assign good_rd  = (state_q == ST_WAIT) && samp_eq
                      && (stable_cnt == SCW'(STABLE_CYCLES - 1));
    assign abort_rd = (state_q == ST_WAIT) && !samp_eq
                      && (retry_cnt == RCW'(MAX_RETRY - 1));

    // Per-bit synchronizer chain and one-edge-delayed copy for the stability compare
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
            samp_prev <= '0;
        end else begin
            sync_q[0] <= cnt_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            samp_prev <= cnt_sync;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept a request in IDLE, leave WAIT on a good read or an abort
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_req) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (good_rd || abort_rd) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values: counters, result capture and last good value
    always_comb begin
        stable_cnt_d = stable_cnt;
        retry_cnt_d  = retry_cnt;
        last_val_d   = last_val;
        rd_valid_d   = 1'b0;
        rd_value_d   = rd_value;
        rd_delta_d   = rd_delta;
        rd_err_d     = rd_err;
        busy_d       = (state_d == ST_WAIT);
        case (state_q)
            ST_IDLE: begin
                if (rd_req) begin
                    stable_cnt_d = '0;
                    retry_cnt_d  = '0;
                end
            end
            ST_WAIT: begin
                if (samp_eq) begin
                    stable_cnt_d = stable_cnt + SCW'(1);
                end else begin
                    stable_cnt_d = '0;
                    retry_cnt_d  = retry_cnt + RCW'(1);
                end
                if (good_rd) begin
                    rd_valid_d = 1'b1;
                    rd_value_d = cnt_sync;
                    rd_delta_d = cnt_sync - last_val;
                    rd_err_d   = 1'b0;
                    last_val_d = cnt_sync;
                end else if (abort_rd) begin
                    rd_valid_d = 1'b1;
                    rd_value_d = cnt_sync;
                    rd_delta_d = '0;
                    rd_err_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and read-control state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stable_cnt <= '0;
            retry_cnt  <= '0;
            last_val   <= '0;
            busy       <= 1'b0;
            rd_valid   <= 1'b0;
            rd_value   <= '0;
            rd_delta   <= '0;
            rd_err     <= 1'b0;
        end else begin
            stable_cnt <= stable_cnt_d;
            retry_cnt  <= retry_cnt_d;
            last_val   <= last_val_d;
            busy       <= busy_d;
            rd_valid   <= rd_valid_d;
            rd_value   <= rd_value_d;
            rd_delta   <= rd_delta_d;
            rd_err     <= rd_err_d;
        end
    end

`ifdef RIPPLE_RD_WRAP_CNT_EN
    // Count good reads whose value is below the previous good value, saturating
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wrap_cnt <= '0;
        end else if (good_rd && (cnt_sync < last_val) && (wrap_cnt != '1)) begin
            wrap_cnt <= wrap_cnt + WRAP_W'(1);
        end
    end
`endif

endmodule
